// File: rtl/motor_pkg.sv
// Shared types and defaults for the motor command sequencer
// and the PWM controller it feeds.
package motor_pkg;

    localparam int C_MULTIPLY_BY   = 33003;
    localparam int C_PWM_FREQ_CLKS = 3333333;

    typedef logic [23:0] duty_t;

    typedef enum logic [1:0] {
        DIR_OFF = 2'd0,
        DIR_CW  = 2'd1,
        DIR_CCW = 2'd2
    } dir_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DIR_WR,
        ST_RAMP_UP,
        ST_RAMP_DOWN,
        ST_RUN,
        ST_DEAD
    } state_e;

    // Code 3 is undefined downstream, so it is folded into off.
    function automatic dir_e norm_dir(input logic [1:0] d);
        return (d == 2'd3) ? DIR_OFF : dir_e'(d);
    endfunction

    function automatic duty_t dir_code(input dir_e d, input int mult);
        return duty_t'(int'(d) * mult);
    endfunction

endpackage

// File: rtl/motor_cmd_sequencer_if.sv
// Direction/duty command channel with a valid/ready handshake.
interface motor_cmd_sequencer_if;
    import motor_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dir;
    duty_t      cmd_duty;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_duty,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_duty,
        output cmd_ready
    );

endinterface

// File: rtl/pwm_period_tick.sv
// Free-running PWM period counter; tick marks the last clock
// of each period.
module pwm_period_tick
    import motor_pkg::*;
#(
    parameter int c_PWM_Freq_Clks = C_PWM_FREQ_CLKS
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    output logic o_Tick
);

    localparam int W =
        (c_PWM_Freq_Clks > 1) ? $clog2(c_PWM_Freq_Clks) : 1;
    localparam logic [W-1:0] LAST = W'(c_PWM_Freq_Clks - 1);

    logic [W-1:0] r_Count;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Count <= '0;
        end else if (r_Count == LAST) begin
            r_Count <= '0;
        end else begin
            r_Count <= r_Count + 1'b1;
        end
    end

    assign o_Tick = (r_Count == LAST);

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Soft-ramping command sequencer in front of the DC motor PWM
// controller; reversals go ramp-down, off, dead time, ramp-up.
module motor_cmd_sequencer
    import motor_pkg::*;
#(
    parameter int c_PWM_Freq_Clks = C_PWM_FREQ_CLKS,
    parameter int c_Multiply_By   = C_MULTIPLY_BY,
    parameter int c_Min_Range     = 10 * c_Multiply_By,
    parameter int c_Ramp_Step     = 33003,
    parameter int c_Dead_Periods  = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    motor_cmd_sequencer_if.slave  cmd,
    output duty_t                 o_Control_Range,
    output logic [1:0]            o_Dir_Active,
    output duty_t                 o_Range_Active,
    output logic                  o_Busy
);

    localparam duty_t C_MIN  = duty_t'(c_Min_Range);
    localparam duty_t C_MAX  = duty_t'(c_PWM_Freq_Clks);
    localparam duty_t C_STEP = duty_t'(c_Ramp_Step);
    localparam int    DW     = $clog2(c_Dead_Periods + 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(c_Dead_Periods - 1);

    function automatic duty_t clamp_duty(input duty_t d);
        duty_t r;
        unique case (1'b1)
            (d < C_MIN): r = C_MIN;
            (d > C_MAX): r = C_MAX;
            default:     r = d;
        endcase
        return r;
    endfunction

    function automatic duty_t ramp_up(input duty_t r, input duty_t t);
        logic [24:0] s;
        s = {1'b0, r} + {1'b0, C_STEP};
        return (s >= {1'b0, t}) ? t : s[23:0];
    endfunction

    // Underflow is caught before the compare against the target.
    function automatic duty_t ramp_dn(input duty_t r, input duty_t t);
        logic [24:0] s;
        if ({1'b0, r} < {1'b0, C_STEP}) return t;
        s = {1'b0, r} - {1'b0, C_STEP};
        return (s <= {1'b0, t}) ? t : s[23:0];
    endfunction

    state_e          r_State;
    duty_t           r_Range;
    duty_t           r_Target;
    duty_t           r_Goal;
    dir_e            r_Dir;
    dir_e            r_New_Dir;
    dir_e            r_Wr_Dir;
    logic            r_Wr_Cnt;
    logic [DW-1:0]   r_Dead_Cnt;

    logic  w_Tick;
    logic  w_Accept;
    dir_e  w_Dir;
    duty_t w_Duty;
    duty_t w_Up;
    duty_t w_Dn;

    pwm_period_tick #(
        .c_PWM_Freq_Clks(c_PWM_Freq_Clks)
    ) u_tick (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .o_Tick  (w_Tick)
    );

    assign w_Accept       = cmd.cmd_valid & cmd.cmd_ready;
    assign w_Dir          = norm_dir(cmd.cmd_dir);
    assign w_Duty         = clamp_duty(cmd.cmd_duty);
    assign w_Up           = ramp_up(r_Range, r_Target);
    assign w_Dn           = ramp_dn(r_Range, r_Target);
    assign o_Dir_Active   = r_Dir;
    assign o_Range_Active = r_Range;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State         <= ST_INIT;
            r_Range         <= C_MIN;
            r_Target        <= C_MIN;
            r_Goal          <= C_MIN;
            r_Dir           <= DIR_OFF;
            r_New_Dir       <= DIR_OFF;
            r_Wr_Dir        <= DIR_OFF;
            r_Wr_Cnt        <= 1'b0;
            r_Dead_Cnt      <= '0;
            o_Control_Range <= '0;
            cmd.cmd_ready   <= 1'b0;
            o_Busy          <= 1'b1;
        end else begin
            unique case (r_State)
                ST_INIT: begin
                    r_Wr_Cnt <= ~r_Wr_Cnt;
                    if (r_Wr_Cnt) begin
                        r_State         <= ST_IDLE;
                        o_Control_Range <= r_Range;
                        cmd.cmd_ready   <= 1'b1;
                        o_Busy          <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (w_Accept && w_Dir != DIR_OFF) begin
                        r_Range         <= C_MIN;
                        r_Goal          <= w_Duty;
                        r_New_Dir       <= w_Dir;
                        r_Wr_Dir        <= w_Dir;
                        r_Wr_Cnt        <= 1'b0;
                        o_Control_Range <= dir_code(w_Dir, c_Multiply_By);
                        r_State         <= ST_DIR_WR;
                        cmd.cmd_ready   <= 1'b0;
                        o_Busy          <= 1'b1;
                    end
                end
                ST_DIR_WR: begin
                    r_Wr_Cnt <= ~r_Wr_Cnt;
                    if (r_Wr_Cnt) begin
                        r_Dir           <= r_Wr_Dir;
                        o_Control_Range <= r_Range;
                        if (r_Wr_Dir != DIR_OFF) begin
                            r_Target <= r_Goal;
                            r_State  <= ST_RAMP_UP;
                        end else if (r_New_Dir != DIR_OFF) begin
                            r_Dead_Cnt <= '0;
                            r_State    <= ST_DEAD;
                        end else begin
                            r_State       <= ST_IDLE;
                            cmd.cmd_ready <= 1'b1;
                            o_Busy        <= 1'b0;
                        end
                    end
                end
                ST_RAMP_UP: begin
                    if (r_Range == r_Target) begin
                        r_State       <= ST_RUN;
                        cmd.cmd_ready <= 1'b1;
                        o_Busy        <= 1'b0;
                    end else if (w_Tick) begin
                        r_Range         <= w_Up;
                        o_Control_Range <= w_Up;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (r_Range == r_Target) begin
                        if (r_New_Dir != r_Dir) begin
                            r_Wr_Dir        <= DIR_OFF;
                            r_Wr_Cnt        <= 1'b0;
                            o_Control_Range <= dir_code(DIR_OFF, c_Multiply_By);
                            r_State         <= ST_DIR_WR;
                        end else begin
                            r_State       <= ST_RUN;
                            cmd.cmd_ready <= 1'b1;
                            o_Busy        <= 1'b0;
                        end
                    end else if (w_Tick) begin
                        r_Range         <= w_Dn;
                        o_Control_Range <= w_Dn;
                    end
                end
                ST_RUN: begin
                    if (w_Accept) begin
                        r_New_Dir <= w_Dir;
                        if (w_Dir != r_Dir) begin
                            r_Goal        <= w_Duty;
                            r_Target      <= C_MIN;
                            r_State       <= ST_RAMP_DOWN;
                            cmd.cmd_ready <= 1'b0;
                            o_Busy        <= 1'b1;
                        end else if (w_Duty > r_Range) begin
                            r_Target      <= w_Duty;
                            r_State       <= ST_RAMP_UP;
                            cmd.cmd_ready <= 1'b0;
                            o_Busy        <= 1'b1;
                        end else if (w_Duty < r_Range) begin
                            r_Target      <= w_Duty;
                            r_State       <= ST_RAMP_DOWN;
                            cmd.cmd_ready <= 1'b0;
                            o_Busy        <= 1'b1;
                        end
                    end
                end
                ST_DEAD: begin
                    if (w_Tick) begin
                        if (r_Dead_Cnt == DEAD_LAST) begin
                            r_Wr_Dir        <= r_New_Dir;
                            r_Wr_Cnt        <= 1'b0;
                            o_Control_Range <= dir_code(r_New_Dir, c_Multiply_By);
                            r_State         <= ST_DIR_WR;
                        end else begin
                            r_Dead_Cnt <= r_Dead_Cnt + 1'b1;
                        end
                    end
                end
                default: r_State <= ST_INIT;
            endcase
        end
    end

endmodule

// File: doc/motor_cmd_sequencer.md
# motor_cmd_sequencer

Command sequencer that sits in front of the DC motor PWM controller and drives its single 24-bit encoded control word. It accepts direction/duty commands over a valid/ready handshake. Duty changes are soft-ramped one step per PWM period, and a direction reversal is sequenced as ramp-down, off, dead time, new direction, ramp-up. The PWM controller never sees an abrupt reversal or an out-of-range duty.

## Interface
- c_PWM_Freq_Clks, 3333333: PWM period in clocks; also the maximum duty range.
- c_Multiply_By, 33003: direction code scale. Encoded word `d*c_Multiply_By` selects direction d (0 off, 1 CW, 2 CCW).
- c_Min_Range, 10*c_Multiply_By: lowest legal duty word. Any word ≥ this value is read downstream as duty.
- c_Ramp_Step, 33003: duty change per PWM period tick.
- c_Dead_Periods, 2: PWM periods spent off between opposite directions.
- i_Clk  in  1  system clock
- i_Rst_n  in  1  asynchronous, active-low reset
- i_Cmd_Valid  in  1  command present
- o_Cmd_Ready  out  1  command accepted when both Valid and Ready are high
- i_Cmd_Dir  in  2  0 off, 1 CW, 2 CCW, 3 treated as off
- i_Cmd_Duty  in  24  target duty, in clocks high per period
- o_Control_Range  out  24  encoded word to the PWM controller
- o_Dir_Active  out  2  direction last written downstream
- o_Range_Active  out  24  current ramped duty
- o_Busy  out  1  sequence in progress

## Operation
- Free-running period counter runs 0..c_PWM_Freq_Clks-1 from reset. The tick pulses for 1 clk when the count equals c_PWM_Freq_Clks-1.
- Target duty is clamped to [c_Min_Range, c_PWM_Freq_Clks].
- States and transitions:
  - INIT → IDLE: after reset, drives dir code 0 for 2 clks.
  - IDLE: off.
  - DIR_WR: outputs `dir*c_Multiply_By` for exactly 2 clks, then updates o_Dir_Active.
  - RAMP_UP / RAMP_DOWN: r_Range moves by c_Ramp_Step on each tick, saturating at the target.
  - RUN: steady.
  - DEAD: waits c_Dead_Periods ticks.
- Command routing:
  - Accept in IDLE with dir off: no-op.
  - Accept in IDLE with dir ≠ off: r_Range=c_Min_Range → DIR_WR(new) → RAMP_UP to target.
  - Accept in RUN, same dir: RAMP_UP or RAMP_DOWN to the new target. If equal to the current duty, stay in RUN.
  - Accept in RUN, dir off: RAMP_DOWN to c_Min_Range → DIR_WR(0) → IDLE.
  - Accept in RUN, opposite dir: RAMP_DOWN to c_Min_Range → DIR_WR(0) → DEAD → DIR_WR(new) → RAMP_UP → RUN.
- o_Control_Range selection:
  - In INIT and DIR_WR: the dir code.
  - Otherwise: r_Range, which is always ≥ c_Min_Range, so the word is never misread as a direction code.
- Ramp arithmetic is done at 25 bits.
  - Up: min(r+step, target).
  - Down: max(r−step, target), with the underflow guarded before compare.

## Timing
- Reset values:
  - o_Control_Range=0
  - o_Dir_Active=0
  - o_Range_Active=c_Min_Range
  - o_Cmd_Ready=0
  - o_Busy=1
  - state=INIT
- o_Cmd_Ready=1 only in IDLE and RUN. o_Busy is its complement.
- Command acceptance:
  - The command is captured on the clock edge where Valid and Ready are both high.
  - Ready drops on the next cycle, except for the IDLE/off no-op and the RUN equal-duty case.
  - Valid held while Ready is low is stalled, not dropped.
- First o_Control_Range change occurs 1 clk after acceptance.
- A ramp step lands 1 clk after the tick.
- Ramp start:
  - A tick coinciding with entry to a RAMP state is ignored; the first step occurs on the next tick.
  - A target already reached at entry exits the RAMP state on the next clk.
- Dead time: entry into DEAD clears the tick count; exit is on the c_Dead_Periods-th tick.
- Reset asserted mid-sequence returns all state to reset values immediately. INIT then forces the downstream direction to off.
- All outputs are registered.

## Structure
- Shared package motor_pkg holds:
  - direction encodings DIR_OFF/DIR_CW/DIR_CCW
  - the state enum
  - the default c_Multiply_By and c_PWM_Freq_Clks
- Sub-module pwm_period_tick: the period counter plus tick output, parameterised by c_PWM_Freq_Clks. It should be reused by the PWM controller itself.

## Test plan
Parameters for all scenarios: c_PWM_Freq_Clks=100, c_Multiply_By=4, c_Min_Range=40, c_Ramp_Step=20, c_Dead_Periods=2.
- Reset release → o_Control_Range=0 for 2 clks, then 40; Ready=1; Dir_Active=0.
- Cmd CW/100 from IDLE → dir code 4 for 2 clks, then 40, 60, 80, 100 on successive ticks; Ready=1 in RUN.
- RUN CW/100, cmd CW/50 → 80, 60, 50 over 3 ticks; Dir_Active stays 1.
- RUN CW/100, cmd CCW/60 → 80, 60, 40, then code 0 for 2 clks, 2 ticks dead, code 8 for 2 clks, then 60.
- Clamp checks:
  - cmd CW/500 settles at 100.
  - cmd CW/10 settles at 40.
  - dir=3 behaves as off: ramp to 40, then code 0.
  - Valid held during busy is accepted only on return to RUN.
- Reset asserted mid-ramp → outputs at reset values the same cycle; INIT sequence replays after release.
